seq_divider32: RTL and testbench
================================

Name: seq_divider32

Overview:
- Multi-cycle unsigned radix-2 restoring divider; the inverse operation to the ALU multiplier path.
- Each step is one trial subtraction (add of two's complement) of the divisor from a shifted partial remainder.
- Produces one quotient bit per clock.
- Sits beside the multiplier in the ALU system; the ALU controller drives it through a start/done handshake.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
op_start  input  1  request a division; sampled only in IDLE and DONE
op_clear  input  1  synchronous abort/clear; returns to IDLE
dividend  input  WIDTH  unsigned dividend, sampled on accepting edge
divisor  input  WIDTH  unsigned divisor, sampled on accepting edge
quotient  output  WIDTH  registered result
remainder  output  WIDTH  registered result
busy  output  1  high while in EXEC
done  output  1  high while in DONE (results valid)
div_by_zero  output  1  high in DONE when the captured divisor was 0

Behaviour:
- One clock (clk). Reset is synchronous, active-high (reset).
- Reset values: state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; internal count=0, R=0, Q=0, D=0.
- States: IDLE, EXEC, DONE. The state is 2-bit encoded. An illegal encoding goes to IDLE on the next edge.
- Priority at every edge: reset > op_clear > op_start > normal progress.
- op_clear in any state:
  - Next state is IDLE.
  - quotient, remainder, div_by_zero and done clear to 0.
  - An in-flight operation is discarded.
- IDLE or DONE with op_start=1 (accepting edge):
  - Capture D=divisor, Q=dividend, R=0 (WIDTH+1 bits), count=0.
  - If divisor!=0: next state is EXEC, busy=1, done=0.
  - If divisor==0: next state is DONE directly. quotient=all ones, remainder=dividend, div_by_zero=1, done=1.
- EXEC, one step per edge:
  - Form {R,Q} shifted left 1; the MSB of Q enters the LSB of R.
  - Compute diff = R_shifted - {0,D} at WIDTH+1 bits.
  - If diff[WIDTH]==0: R=diff, Q[0]=1. Otherwise R=R_shifted, Q[0]=0.
  - count increments.
- Completion: on the step where count reaches WIDTH, next state is DONE, quotient=Q, remainder=R[WIDTH-1:0], div_by_zero=0, busy=0, done=1.
- Latency: done is high exactly WIDTH clock cycles after the accepting edge (32 for the default).
- op_start during EXEC is ignored. Operands are not re-sampled and no error is flagged.
- DONE holds done, quotient and remainder indefinitely until op_start (new op; done falls next cycle) or op_clear.
- Back-to-back: op_start held high continuously gives one result every WIDTH+1 cycles. Done is high for exactly 1 cycle each time.
- quotient and remainder update only on DONE entry (or clear/reset). They are stable during EXEC.
- Invariant for nonzero divisor: dividend == quotient*divisor + remainder and remainder < divisor.
- Reset or op_clear mid-EXEC leaves no residue: the next operation's result is independent of the aborted one.

Test Plan:
- reset, then dividend=100, divisor=7, pulse op_start -> busy for 32 cycles; done high on cycle 32; quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then divisor=0xFFFFFFFF with dividend=0xFFFFFFFE -> quotient=0, remainder=0xFFFFFFFE.
- dividend=55, divisor=0 -> DONE on the next cycle with quotient=0xFFFFFFFF, remainder=55, div_by_zero=1, busy never asserted.
- Start 1000/3; at cycle 10 pulse op_start with 9/9 (ignored); at completion quotient=333, remainder=1. Then pulse op_clear -> done=0, quotient=0, remainder=0, state IDLE.
- Start 12345/10, assert reset at cycle 15 -> all outputs 0 next cycle. Then start 8/3 -> quotient=2, remainder=2 with latency 32.
- 2000 random (dividend, divisor!=0) pairs with op_start held high -> each result satisfies q*d+r==dividend and r<d; done pulses every 33 cycles.

Source files
------------

// File: rtl/seq_divider32.sv
// Multi-cycle unsigned radix-2 restoring divider, one quotient bit per clock.
// Start/done handshake toward the ALU controller; divide-by-zero short-cuts to DONE.
//
//   state | meaning
//   IDLE  | waiting for op_start, outputs hold last cleared/reset values
//   EXEC  | one trial subtraction per clock, busy high
//   DONE  | results valid, done high until op_start or op_clear
module seq_divider32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_start,
   input  logic             op_clear,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_d, rem_d;
   logic             dbz_d;

   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] r_step;
   logic [WIDTH-1:0] q_step;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         cnt_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         q_q         <= q_d;
         d_q         <= d_d;
         cnt_q       <= cnt_d;
         quotient    <= quot_d;
         remainder   <= rem_d;
         div_by_zero <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quot_d  = quotient;
      rem_d   = remainder;
      dbz_d   = div_by_zero;

      // The partial remainder is always below D, so WIDTH bits hold it; the
      // shifted value needs one extra bit for the sign of the trial subtraction.
      r_sh   = {r_q, q_q[WIDTH-1]};
      diff   = r_sh - {1'b0, d_q};
      r_step = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      q_step = {q_q[WIDTH-2:0], ~diff[WIDTH]};

      if (op_clear) begin
         state_d = ST_IDLE;
         r_d     = '0;
         q_d     = '0;
         d_d     = '0;
         cnt_d   = '0;
         quot_d  = '0;
         rem_d   = '0;
         dbz_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (op_start) begin
                  d_d   = divisor;
                  q_d   = dividend;
                  r_d   = '0;
                  cnt_d = '0;
                  if (divisor == '0) begin
                     state_d = ST_DONE;
                     quot_d  = '1;
                     rem_d   = dividend;
                     dbz_d   = 1'b1;
                  end else begin
                     state_d = ST_EXEC;
                     dbz_d   = 1'b0;
                  end
               end
            end
            ST_EXEC: begin
               r_d   = r_step;
               q_d   = q_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == LAST) begin
                  state_d = ST_DONE;
                  quot_d  = q_step;
                  rem_d   = r_step;
                  dbz_d   = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign busy = (state_q == ST_EXEC);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_divider32.sv
// Directed and random back-to-back checks for seq_divider32.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_seq_divider32;

   logic        clk = 1'b0;
   logic        reset, op_start, op_clear;
   logic [31:0] dividend, divisor;
   logic [31:0] quotient, remainder;
   logic        busy, done, div_by_zero;

   int vectors = 0;
   int miscompares = 0;

   seq_divider32 #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .op_start(op_start), .op_clear(op_clear),
      .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder),
      .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      dividend = a;
      divisor  = b;
      op_start = 1'b1;
      tick();
      op_start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      logic [31:0] a, b;
      longint unsigned recon;

      reset = 1'b1; op_start = 1'b0; op_clear = 1'b0;
      dividend = '0; divisor = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

      // 100 / 7
      start_op(32'd100, 32'd7);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_done_low", {31'd0, done}, 32'd0);
      wait_done(cyc);
      chk("t1_latency", cyc, 32'd32);
      chk("t1_quotient", quotient, 32'd14);
      chk("t1_remainder", remainder, 32'd2);
      chk("t1_dbz", {31'd0, div_by_zero}, 32'd0);
      chk("t1_busy_off", {31'd0, busy}, 32'd0);
      tick(); tick();
      chk("t1_hold_done", {31'd0, done}, 32'd1);
      chk("t1_hold_q", quotient, 32'd14);

      // extremes
      start_op(32'hFFFF_FFFF, 32'd1);
      chk("t2a_done_fall", {31'd0, done}, 32'd0);
      wait_done(cyc);
      chk("t2a_latency", cyc, 32'd32);
      chk("t2a_quotient", quotient, 32'hFFFF_FFFF);
      chk("t2a_remainder", remainder, 32'd0);
      start_op(32'hFFFF_FFFE, 32'hFFFF_FFFF);
      wait_done(cyc);
      chk("t2b_quotient", quotient, 32'd0);
      chk("t2b_remainder", remainder, 32'hFFFF_FFFE);

      // divide by zero
      start_op(32'd55, 32'd0);
      chk("t3_done", {31'd0, done}, 32'd1);
      chk("t3_busy", {31'd0, busy}, 32'd0);
      chk("t3_quotient", quotient, 32'hFFFF_FFFF);
      chk("t3_remainder", remainder, 32'd55);
      chk("t3_dbz", {31'd0, div_by_zero}, 32'd1);
      tick();
      chk("t3_busy_hold", {31'd0, busy}, 32'd0);
      chk("t3_done_hold", {31'd0, done}, 32'd1);

      // op_start during EXEC is ignored
      start_op(32'd1000, 32'd3);
      for (int i = 0; i < 9; i++) tick();
      chk("t4_q_stable", quotient, 32'hFFFF_FFFF);
      dividend = 32'd9; divisor = 32'd9; op_start = 1'b1;
      tick();
      op_start = 1'b0;
      chk("t4_busy_mid", {31'd0, busy}, 32'd1);
      wait_done(cyc);
      chk("t4_latency", cyc + 10, 32'd32);
      chk("t4_quotient", quotient, 32'd333);
      chk("t4_remainder", remainder, 32'd1);
      op_clear = 1'b1;
      tick();
      op_clear = 1'b0;
      chk("t4_clr_done", {31'd0, done}, 32'd0);
      chk("t4_clr_q", quotient, 32'd0);
      chk("t4_clr_r", remainder, 32'd0);
      tick();
      chk("t4_idle_busy", {31'd0, busy}, 32'd0);
      chk("t4_idle_done", {31'd0, done}, 32'd0);

      // reset mid-EXEC, then a clean operation
      start_op(32'd12345, 32'd10);
      for (int i = 0; i < 14; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_rst_done", {31'd0, done}, 32'd0);
      chk("t5_rst_q", quotient, 32'd0);
      chk("t5_rst_r", remainder, 32'd0);
      start_op(32'd8, 32'd3);
      wait_done(cyc);
      chk("t5_latency", cyc, 32'd32);
      chk("t5_quotient", quotient, 32'd2);
      chk("t5_remainder", remainder, 32'd2);

      // op_clear mid-EXEC, then a clean operation
      start_op(32'hDEAD_BEEF, 32'd5);
      for (int i = 0; i < 7; i++) tick();
      op_clear = 1'b1;
      tick();
      op_clear = 1'b0;
      chk("t6_clr_busy", {31'd0, busy}, 32'd0);
      start_op(32'd50, 32'd7);
      wait_done(cyc);
      chk("t6_latency", cyc, 32'd32);
      chk("t6_quotient", quotient, 32'd7);
      chk("t6_remainder", remainder, 32'd1);

      // random back-to-back with op_start held high
      op_start = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (b == 32'd0) b = 32'd1;
         dividend = a;
         divisor  = b;
         tick();
         chk("rnd_done_pulse", {31'd0, done}, 32'd0);
         wait_done(cyc);
         chk("rnd_period", cyc + 1, 32'd33);
         if (cyc >= 100) break;
         recon = longint'(quotient) * longint'(b) + longint'(remainder);
         vectors++;
         assert (recon === longint'(a)) else begin
            miscompares++;
            $error("FAIL rnd_invariant: observed %0h expected %0h", recon, a);
         end
         vectors++;
         assert (remainder < b) else begin
            miscompares++;
            $error("FAIL rnd_rem_lt_div: observed %0h expected below %0h", remainder, b);
         end
      end
      op_start = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
